// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester holding-slot signals plus the UART TX start/done handshake.
// The arbiter connects via the slave modport; the requesters/UART side uses master.
interface uart_tx_arbiter_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned N_REQ   = 4
);
    logic [N_REQ-1:0]         i_req_start;
    logic [N_REQ*NB_DATA-1:0] i_req_data;
    logic [N_REQ-1:0]         o_req_busy;
    logic [N_REQ-1:0]         o_req_overflow;
    logic                     o_tx_start;
    logic [NB_DATA-1:0]       o_tx_data;
    logic                     i_tx_done;
    logic [N_REQ-1:0]         o_grant;
    logic                     o_timeout;

    modport master (
        output i_req_start, i_req_data, i_tx_done,
        input  o_req_busy, o_req_overflow, o_tx_start, o_tx_data, o_grant, o_timeout
    );

    modport slave (
        input  i_req_start, i_req_data, i_tx_done,
        output o_req_busy, o_req_overflow, o_tx_start, o_tx_data, o_grant, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ one-byte holding slots.
// Round-robin scan from ptr picks the next busy slot; one byte in flight at a time;
// an optional watchdog abandons a transfer whose done pulse never arrives.
module uart_tx_arbiter #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned NB_TIMEOUT     = 16
) (
    input logic              i_clk,
    input logic              i_reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned           NB_PTR    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [NB_PTR-1:0]     LAST_REQ  = NB_PTR'(N_REQ - 1);
    // Only meaningful when the watchdog is enabled (TIMEOUT_CYCLES != 0).
    localparam logic [NB_TIMEOUT-1:0] WDOG_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StWaitDone} state_e;

    state_e              state_q;
    logic [NB_PTR-1:0]   ptr_q;
    logic [N_REQ-1:0]    busy_q;
    logic [N_REQ-1:0]    ovf_q;
    logic [NB_DATA-1:0]  slot_data_q [N_REQ];
    logic                tx_start_q;
    logic [NB_DATA-1:0]  tx_data_q;
    logic [N_REQ-1:0]    grant_q;
    logic                timeout_q;
    logic [NB_TIMEOUT-1:0] wdog_q;

    logic              win_found;
    logic [NB_PTR-1:0] win_idx;
    logic [N_REQ-1:0]  win_oh;
    logic              issue;
    int unsigned       scan_idx;

    // Round-robin pick: first busy slot at or after ptr, wrapping modulo N_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = (32'(ptr_q) + k) % N_REQ;
            if (!win_found && busy_q[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = NB_PTR'(scan_idx);
            end
        end
        win_oh = N_REQ'(1) << win_idx;
        issue  = (state_q == StIdle) && win_found;
    end

    // Holding slots: capture when free, flag overflow when busy, free when issued
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q <= '0;
            ovf_q  <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (issue && win_oh[i]) begin
                    busy_q[i] <= 1'b0;
                end
                // Judged on the registered busy bit, so a start in the issue cycle overflows.
                if (bus.i_req_start[i]) begin
                    if (busy_q[i]) begin
                        ovf_q[i] <= 1'b1;
                    end else begin
                        busy_q[i]      <= 1'b1;
                        slot_data_q[i] <= bus.i_req_data[i*NB_DATA +: NB_DATA];
                    end
                end
            end
        end
    end

    // Scheduler FSM: issue one byte, then wait for done or watchdog expiry
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            timeout_q  <= 1'b0;
            wdog_q     <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Done pulses seen here belong to no transfer and are ignored.
                    if (win_found) begin
                        tx_data_q  <= slot_data_q[win_idx];
                        tx_start_q <= 1'b1;
                        grant_q    <= win_oh;
                        ptr_q      <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
                        wdog_q     <= '0;
                        state_q    <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (bus.i_tx_done) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (wdog_q == WDOG_LAST) begin
                            state_q   <= StIdle;
                            grant_q   <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.o_req_busy     = busy_q;
    assign bus.o_req_overflow = ovf_q;
    assign bus.o_tx_start     = tx_start_q;
    assign bus.o_tx_data      = tx_data_q;
    assign bus.o_grant        = grant_q;
    assign bus.o_timeout      = timeout_q;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between up to N_REQ byte producers, such as the ALU command front-end, a status reporter and a debug dump unit. Each requester owns a one-byte holding slot. A round-robin scheduler drains the slots into the transmitter one byte at a time, pulsing the TX start and waiting for TX done. A watchdog recovers from a transmitter that never reports done.

## Interface
Parameters:
- NB_DATA, 8, byte width.
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 0, maximum cycles to wait for i_tx_done; 0 disables the watchdog.
- NB_TIMEOUT, 16, width of the watchdog counter.

Ports:
- i_clk, in, 1, the single clock.
- i_reset, in, 1, reset: synchronous, active-high.
- i_req_start, in, N_REQ, per-requester one-cycle pulse: "send i_req_data[i]".
- i_req_data, in, N_REQ*NB_DATA, packed bytes; requester i uses bits [i*NB_DATA +: NB_DATA].
- o_req_busy, out, N_REQ, slot i occupied; a start pulse is not accepted while this is high.
- o_req_overflow, out, N_REQ, sticky flag: a start pulse arrived while the slot was busy.
- o_tx_start, out, 1, one-cycle pulse to the UART TX.
- o_tx_data, out, NB_DATA, byte to the UART TX; held stable from the start pulse until done or timeout.
- i_tx_done, in, 1, one-cycle pulse from the UART TX when the byte has been sent.
- o_grant, out, N_REQ, one-hot owner of the current transfer; 0 when idle.
- o_timeout, out, 1, sticky flag: the watchdog fired at least once.

## Operation
- Slots: on the i_req_start[i] pulse with o_req_busy[i]=0, capture i_req_data[i] and set busy[i].
  - A start with busy[i]=1, judged by the registered value in that cycle, is dropped and sets o_req_overflow[i].
  - Busy[i] clears when the arbiter issues the slot's byte.
- FSM states: IDLE, WAIT_DONE.
- IDLE, with any busy bit set:
  - Select the first busy slot scanning upward from ptr, wrapping modulo N_REQ.
  - On the next edge: o_tx_data <= slot data, o_tx_start <= 1 for one cycle, o_grant <= one-hot of the winner, clear that slot's busy bit, ptr <= winner+1 (wrapping), clear the watchdog, state <= WAIT_DONE.
- IDLE, with no busy bit set: hold, o_grant=0.
- WAIT_DONE:
  - On i_tx_done: state <= IDLE, o_grant <= 0.
  - Otherwise, if TIMEOUT_CYCLES != 0, increment the watchdog. When it reaches TIMEOUT_CYCLES-1 without a done: state <= IDLE, o_grant <= 0, o_timeout <= 1.
- i_tx_done in IDLE is ignored.
- Slot captures continue in every state, including for the requester currently granted.
- Reset (from any state, including mid-transfer) forces:
  - state=IDLE, ptr=0;
  - all busy, overflow and grant bits to 0;
  - o_tx_start=0, o_tx_data=0, o_timeout=0, watchdog=0.
  - Pending slot bytes are discarded. A transfer already started in the UART is not aborted; its later i_tx_done is ignored because the FSM is in IDLE.

## Timing
- All outputs are registered.
- Start-to-issue latency: pulse sampled at edge k → busy high after k → o_tx_start high in the cycle after edge k+1.
- Done-to-next-issue: i_tx_done at edge m → IDLE after m → next o_tx_start after edge m+1. There is one idle cycle minimum between transfers.
- Occupancy: WAIT_DONE always lasts at least 1 cycle, even if i_tx_done coincides with the start pulse cycle.
- Simultaneous start on several requesters: all are captured on the same edge and serviced in round-robin order.
- Re-arm: a requester may re-pulse start from the cycle after its o_tx_start, because busy is already clear.
- o_req_overflow and o_timeout clear only on reset.

## Test plan
- Single byte: after reset, pulse i_req_start[1] with 0xA5 → o_tx_start one cycle, 2 cycles after the start pulse, o_tx_data=0xA5, o_grant=4'b0010. Hold done off 5 cycles and then pulse it → o_grant=0, no further start.
- Contention: pulse starts 0..3 together with 0x10/0x11/0x12/0x13, answering each start with done 3 cycles later → bytes appear in order 0x10, 0x11, 0x12, 0x13, with exactly one idle cycle between done and the next start.
- Fairness/wrap: after a grant to requester 2, load slots 1 and 3 → 3 is served first, then 1. Afterwards ptr wraps to requester 2, so a subsequent load of slots 0 and 3 serves 3 before 0.
- Overflow: pulse start[0] twice on consecutive cycles with 0x01 then 0x02 → only 0x01 is transmitted, o_req_overflow=4'b0001, and it stays set until reset.
- Watchdog: TIMEOUT_CYCLES=8, never assert done → FSM returns to IDLE after 8 cycles of WAIT_DONE and o_timeout=1. A pending slot is then issued on the next cycle.
- Reset mid-operation: assert i_reset while in WAIT_DONE with two slots busy → next cycle all outputs are 0 and no start follows. A late i_tx_done is ignored.
